// File: rtl/scpu_sequencer_pkg.sv
// Shared opcode, state and strobe encodings for the sequencer and datapath.
package scpu_sequencer_pkg;

  localparam int unsigned IR_W     = 8;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_MOV = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_LD  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_ST  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_LDR = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_STR = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_RSV = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam logic [SEL_W-1:0] ADDR_PC = 2'b00;
  localparam logic [SEL_W-1:0] ADDR_RS = 2'b01;
  localparam logic [SEL_W-1:0] ADDR_DR = 2'b10;

  localparam logic [SEL_W-1:0] RF_SRC_ALU = 2'b00;
  localparam logic [SEL_W-1:0] RF_SRC_DR  = 2'b01;
  localparam logic [SEL_W-1:0] RF_SRC_MEM = 2'b10;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b100;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  // One cycle's worth of datapath control.
  typedef struct packed {
    logic                load_ir;
    logic                load_pc;
    logic                load_dr;
    logic                imm;
    logic                mem_wr;
    logic [SEL_W-1:0]    addr_sel;
    logic                rf_we;
    logic [SEL_W-1:0]    rf_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                flag_we;
  } strobe_t;

endpackage

// File: rtl/scpu_sequencer_if.sv
// Sequencer <-> fetch/datapath signal bundle.
interface scpu_sequencer_if;
  import scpu_sequencer_pkg::*;

  logic                cpu_en;
  logic [IR_W-1:0]     fetch_ir;
  logic                alu_z;
  logic                alu_c;
  logic                dc_load_ir;
  logic                dc_load_pc;
  logic                dc_load_dr;
  logic                dc_imm;
  logic                dc_mem_wr;
  logic [SEL_W-1:0]    dc_addr_sel;
  logic                dc_rf_we;
  logic [SEL_W-1:0]    dc_rf_src;
  logic [IDX_W-1:0]    dc_rd_idx;
  logic [IDX_W-1:0]    dc_rs_idx;
  logic [ALU_OP_W-1:0] dc_alu_op;
  logic                dc_flag_we;
  logic                seq_halt;
  logic [1:0]          seq_state;

  modport master (
    input  cpu_en, fetch_ir, alu_z, alu_c,
    output dc_load_ir, dc_load_pc, dc_load_dr, dc_imm, dc_mem_wr,
           dc_addr_sel, dc_rf_we, dc_rf_src, dc_rd_idx, dc_rs_idx,
           dc_alu_op, dc_flag_we, seq_halt, seq_state
  );

  modport slave (
    output cpu_en, fetch_ir, alu_z, alu_c,
    input  dc_load_ir, dc_load_pc, dc_load_dr, dc_imm, dc_mem_wr,
           dc_addr_sel, dc_rf_we, dc_rf_src, dc_rd_idx, dc_rs_idx,
           dc_alu_op, dc_flag_we, seq_halt, seq_state
  );

endinterface

// File: rtl/scpu_sequencer_op_decode.sv
// Pure combinational opcode classifier for the sequencer.
module scpu_sequencer_op_decode
  import scpu_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_z,
  input  logic                alu_c,
  output logic                is_alu,
  output logic                is_mov,
  output logic                is_ldi,
  output logic                is_ld,
  output logic                is_st,
  output logic                is_ldr,
  output logic                is_str,
  output logic                is_two_byte,
  output logic                is_jump,
  output logic                jump_taken,
  output logic                is_halt
);

  // Opcode classes; jump condition resolved against current flags.
  always_comb begin
    is_alu      = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);
    is_mov      = (opcode == OP_MOV);
    is_ldi      = (opcode == OP_LDI);
    is_ld       = (opcode == OP_LD);
    is_st       = (opcode == OP_ST);
    is_ldr      = (opcode == OP_LDR);
    is_str      = (opcode == OP_STR);
    is_halt     = (opcode == OP_HLT);
    is_jump     = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_JC);
    is_two_byte = is_ldi || is_ld || is_st || is_jump;
    jump_taken  = (opcode == OP_JMP) ||
                  ((opcode == OP_JZ) && alu_z) ||
                  ((opcode == OP_JC) && alu_c);
  end

endmodule

// File: rtl/scpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH / DECODE / EXEC / HALT.
module scpu_sequencer
  import scpu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  scpu_sequencer_if.master  bus
);

  state_t              state;
  state_t              state_next;
  strobe_t             strb;
  logic [OPCODE_W-1:0] opcode;

  logic is_alu, is_mov, is_ldi, is_ld, is_st, is_ldr, is_str;
  logic is_two_byte, is_jump, jump_taken, is_halt;

  assign opcode = bus.fetch_ir[7:4];

  scpu_sequencer_op_decode u_op_decode (
    .opcode      (opcode),
    .alu_z       (bus.alu_z),
    .alu_c       (bus.alu_c),
    .is_alu      (is_alu),
    .is_mov      (is_mov),
    .is_ldi      (is_ldi),
    .is_ld       (is_ld),
    .is_st       (is_st),
    .is_ldr      (is_ldr),
    .is_str      (is_str),
    .is_two_byte (is_two_byte),
    .is_jump     (is_jump),
    .jump_taken  (jump_taken),
    .is_halt     (is_halt)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Next-state: a taken jump goes straight to DECODE with the target opcode.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_FETCH:  state_next = bus.cpu_en ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (is_halt)          state_next = ST_HALT;
        else if (is_two_byte) state_next = ST_EXEC;
        else                  state_next = ST_FETCH;
      end
      ST_EXEC:   state_next = (is_jump && jump_taken) ? ST_DECODE : ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  // Strobe generation; everything is held at zero while reset is asserted.
  always_comb begin
    strb = '0;
    if (rst_n) begin
      unique case (state)
        ST_FETCH: begin
          if (bus.cpu_en) begin
            strb.load_ir  = 1'b1;
            strb.load_pc  = 1'b1;
            strb.imm      = 1'b0;
            strb.addr_sel = ADDR_PC;
          end
        end
        ST_DECODE: begin
          if (is_alu) begin
            strb.rf_we   = 1'b1;
            strb.rf_src  = RF_SRC_ALU;
            strb.flag_we = 1'b1;
            strb.alu_op  = ALU_OP_W'(opcode[2:0]);
          end else if (is_mov) begin
            strb.rf_we  = 1'b1;
            strb.rf_src = RF_SRC_ALU;
            strb.alu_op = ALU_PASS;
          end else if (is_ldr) begin
            strb.addr_sel = ADDR_RS;
            strb.rf_we    = 1'b1;
            strb.rf_src   = RF_SRC_MEM;
          end else if (is_str) begin
            strb.addr_sel = ADDR_RS;
            strb.mem_wr   = 1'b1;
          end else if (is_two_byte) begin
            // Second byte is read at PC into DR while PC steps past it.
            strb.load_dr  = 1'b1;
            strb.load_pc  = 1'b1;
            strb.imm      = 1'b0;
            strb.addr_sel = ADDR_PC;
          end
        end
        ST_EXEC: begin
          if (is_ldi) begin
            strb.rf_we  = 1'b1;
            strb.rf_src = RF_SRC_DR;
          end else if (is_ld) begin
            strb.addr_sel = ADDR_DR;
            strb.rf_we    = 1'b1;
            strb.rf_src   = RF_SRC_MEM;
          end else if (is_st) begin
            strb.addr_sel = ADDR_DR;
            strb.mem_wr   = 1'b1;
          end else if (is_jump && jump_taken) begin
            // Fetch the target directly: IR <= mem[DR], PC <= DR + 1.
            strb.load_ir = 1'b1;
            strb.load_pc = 1'b1;
            strb.imm     = 1'b1;
          end
        end
        ST_HALT: strb = '0;
        default: strb = '0;
      endcase
    end
  end

  assign bus.dc_load_ir  = strb.load_ir;
  assign bus.dc_load_pc  = strb.load_pc;
  assign bus.dc_load_dr  = strb.load_dr;
  assign bus.dc_imm      = strb.imm;
  assign bus.dc_mem_wr   = strb.mem_wr;
  assign bus.dc_addr_sel = strb.addr_sel;
  assign bus.dc_rf_we    = strb.rf_we;
  assign bus.dc_rf_src   = strb.rf_src;
  assign bus.dc_alu_op   = strb.alu_op;
  assign bus.dc_flag_we  = strb.flag_we;
  assign bus.dc_rd_idx   = bus.fetch_ir[3:2];
  assign bus.dc_rs_idx   = bus.fetch_ir[1:0];
  assign bus.seq_halt    = rst_n && (state == ST_HALT);
  assign bus.seq_state   = rst_n ? 2'(state) : 2'(ST_FETCH);

endmodule

// File: tb/tb_scpu_sequencer.sv
// Directed bench for scpu_sequencer.
module tb_scpu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  scpu_sequencer_if bus ();

  scpu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {load_ir, load_pc, load_dr, imm, mem_wr, addr_sel, rf_we, rf_src, alu_op, flag_we}
  function automatic logic [13:0] mk(input logic li, input logic lp, input logic ld,
                                     input logic im, input logic mw, input logic [1:0] as,
                                     input logic we, input logic [1:0] src,
                                     input logic [2:0] op, input logic fw);
    return {li, lp, ld, im, mw, as, we, src, op, fw};
  endfunction

  logic [13:0] obs_s;
  assign obs_s = {bus.dc_load_ir, bus.dc_load_pc, bus.dc_load_dr, bus.dc_imm,
                  bus.dc_mem_wr, bus.dc_addr_sel, bus.dc_rf_we, bus.dc_rf_src,
                  bus.dc_alu_op, bus.dc_flag_we};

  localparam logic [13:0] S_NONE  = 14'h0;
  logic [13:0] s_fetch, s_dr, s_jump;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [13:0] es,
                            input logic [1:0] est, input logic eh);
    chk({tag, "_strobes"}, 32'(obs_s), 32'(es));
    chk({tag, "_state"}, 32'(bus.seq_state), 32'(est));
    chk({tag, "_halt"}, 32'(bus.seq_halt), 32'(eh));
  endtask

  task automatic expect_idx(input string tag, input logic [1:0] rd, input logic [1:0] rs);
    chk({tag, "_rd"}, 32'(bus.dc_rd_idx), 32'(rd));
    chk({tag, "_rs"}, 32'(bus.dc_rs_idx), 32'(rs));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    s_fetch = mk(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    s_dr    = mk(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    s_jump  = mk(1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0);

    rst_n = 1'b0;
    bus.cpu_en = 1'b1;
    bus.fetch_ir = 8'h70;
    bus.alu_z = 1'b0;
    bus.alu_c = 1'b0;

    // Reset held for two edges; strobes forced low even with cpu_en=1.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    expect_out("reset", S_NONE, 2'b00, 1'b0);
    rst_n = 1'b1; #1;
    expect_out("fetch0", s_fetch, 2'b00, 1'b0);

    // ADD r1,r2
    tick(); bus.fetch_ir = 8'h06; #1;
    expect_out("add_dec", mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b000, 1), 2'b01, 1'b0);
    expect_idx("add", 2'd1, 2'd2);
    tick(); #1; expect_out("add_fetch", s_fetch, 2'b00, 1'b0);

    // LDI r3,#imm
    tick(); bus.fetch_ir = 8'h5C; #1;
    expect_out("ldi_dec", s_dr, 2'b01, 1'b0);
    expect_idx("ldi", 2'd3, 2'd0);
    tick(); #1; expect_out("ldi_exec", mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 3'b000, 0), 2'b10, 1'b0);
    tick(); #1; expect_out("ldi_fetch", s_fetch, 2'b00, 1'b0);

    // ST [a],r0
    tick(); bus.fetch_ir = 8'h80; #1;
    expect_out("st_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("st_exec", mk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0), 2'b10, 1'b0);
    tick(); #1; expect_out("st_fetch", s_fetch, 2'b00, 1'b0);

    // JZ taken, target is another JZ that is not taken
    tick(); bus.fetch_ir = 8'hA0; bus.alu_z = 1'b1; #1;
    expect_out("jz_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("jz_exec_taken", s_jump, 2'b10, 1'b0);
    tick(); bus.alu_z = 1'b0; #1;
    expect_out("jz_target_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("jz_exec_nt", S_NONE, 2'b10, 1'b0);
    tick(); #1; expect_out("jz_nt_fetch", s_fetch, 2'b00, 1'b0);

    // cpu_en low in FETCH: idle for three cycles
    bus.cpu_en = 1'b0; #1;
    expect_out("idle0", S_NONE, 2'b00, 1'b0);
    tick(); #1; expect_out("idle1", S_NONE, 2'b00, 1'b0);
    tick(); #1; expect_out("idle2", S_NONE, 2'b00, 1'b0);
    tick(); bus.cpu_en = 1'b1; #1;
    expect_out("resume_fetch", s_fetch, 2'b00, 1'b0);

    // HLT, then ten cycles in HALT with cpu_en toggling
    tick(); bus.fetch_ir = 8'hF0; #1;
    expect_out("hlt_dec", S_NONE, 2'b01, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.cpu_en = (i % 2 == 0) ? 1'b0 : 1'b1; #1;
      expect_out("halt_hold", S_NONE, 2'b11, 1'b1);
      tick();
    end
    rst_n = 1'b0; #1;
    expect_out("halt_rst", S_NONE, 2'b00, 1'b0);
    bus.cpu_en = 1'b1;
    tick(); rst_n = 1'b1; #1;
    expect_out("post_halt_fetch", s_fetch, 2'b00, 1'b0);

    // MOV r2,r3
    tick(); bus.fetch_ir = 8'h4B; #1;
    expect_out("mov_dec", mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b100, 0), 2'b01, 1'b0);
    expect_idx("mov", 2'd2, 2'd3);
    tick(); #1; expect_out("mov_fetch", s_fetch, 2'b00, 1'b0);

    // LDR r2,[r1]
    tick(); bus.fetch_ir = 8'hC9; #1;
    expect_out("ldr_dec", mk(0, 0, 0, 0, 0, 2'b01, 1, 2'b10, 3'b000, 0), 2'b01, 1'b0);
    expect_idx("ldr", 2'd2, 2'd1);
    tick(); #1; expect_out("ldr_fetch", s_fetch, 2'b00, 1'b0);

    // STR [r1],r2
    tick(); bus.fetch_ir = 8'hD9; #1;
    expect_out("str_dec", mk(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 3'b000, 0), 2'b01, 1'b0);
    tick(); #1; expect_out("str_fetch", s_fetch, 2'b00, 1'b0);

    // LD r1,[a]
    tick(); bus.fetch_ir = 8'h64; #1;
    expect_out("ld_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("ld_exec", mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0), 2'b10, 1'b0);
    tick(); #1; expect_out("ld_fetch", s_fetch, 2'b00, 1'b0);

    // JMP is unconditional; its target is a JC with carry clear
    tick(); bus.fetch_ir = 8'h90; bus.alu_z = 1'b0; bus.alu_c = 1'b0; #1;
    expect_out("jmp_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("jmp_exec", s_jump, 2'b10, 1'b0);
    tick(); bus.fetch_ir = 8'hB0; #1;
    expect_out("jc_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("jc_exec_nt", S_NONE, 2'b10, 1'b0);
    tick(); #1; expect_out("jc_nt_fetch", s_fetch, 2'b00, 1'b0);

    // Reserved opcode behaves as NOP
    tick(); bus.fetch_ir = 8'hE5; #1;
    expect_out("rsv_dec", S_NONE, 2'b01, 1'b0);
    tick(); #1; expect_out("rsv_fetch", s_fetch, 2'b00, 1'b0);

    // SUB r1,r3
    tick(); bus.fetch_ir = 8'h17; #1;
    expect_out("sub_dec", mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b001, 1), 2'b01, 1'b0);
    tick(); #1; expect_out("sub_fetch", s_fetch, 2'b00, 1'b0);

    // JC taken with carry set, target ADD decodes right away
    tick(); bus.fetch_ir = 8'hB0; bus.alu_c = 1'b1; #1;
    expect_out("jc2_dec", s_dr, 2'b01, 1'b0);
    tick(); #1; expect_out("jc2_exec_taken", s_jump, 2'b10, 1'b0);
    tick(); bus.fetch_ir = 8'h06; #1;
    expect_out("jc2_target_dec", mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b000, 1), 2'b01, 1'b0);

    // Reset in the middle of DECODE aborts the instruction
    rst_n = 1'b0; #1;
    expect_out("rst_mid_dec", S_NONE, 2'b00, 1'b0);
    tick(); rst_n = 1'b1; #1;
    expect_out("rst_mid_fetch", s_fetch, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scpu_sequencer.md
# scpu_sequencer

Multi-cycle instruction sequencer for the 8-bit CPU. It sits between the fetch unit and the register file/ALU. It decodes `fetch_ir` and steps a small FSM that drives every `dc_*` strobe: IR/DR/PC loads, RAM address select, RAM write, register-file write, ALU op and flag write. Its job is to run the shared single-port RAM and PC through the fetch, operand, execute and jump phases of each instruction.

## Interface
Parameters:
- none. Opcodes and state codes are localparams from the shared header.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `cpu_en`  in  1  run enable; sampled only in FETCH.
- `fetch_ir`  in  8  current instruction; `[7:4]` opcode, `[3:2]` rd, `[1:0]` rs.
- `alu_z`, `alu_c`  in  1 each  registered zero/carry flags from the datapath.
- `dc_load_ir`, `dc_load_pc`, `dc_load_dr`, `dc_imm`, `dc_mem_wr`  out  1 each  fetch-unit strobes.
- `dc_addr_sel`  out  2  RAM address source: 00 = PC, 01 = rs register, 10 = DR.
- `dc_rf_we`  out  1  register-file write enable.
- `dc_rf_src`  out  2  register-file write source: 00 = ALU, 01 = DR, 10 = RAM data.
- `dc_rd_idx`, `dc_rs_idx`  out  2 each  register indices, straight from `fetch_ir`.
- `dc_alu_op`  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASS-rs.
- `dc_flag_we`  out  1  flag register update.
- `seq_halt`  out  1  CPU halted.
- `seq_state`  out  2  FSM state, for debug.

## Operation
Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR: ALU ops, 1 byte.
- 4 MOV rd,rs: 1 byte.
- 5 LDI rd,#imm; 6 LD rd,[a]; 8 ST [a],rs; 9 JMP a; A JZ a; B JC a: 2 bytes; the second byte is loaded into DR.
- C LDR rd,[rs]; D STR [rs],rd: 1 byte.
- 7 NOP (the IR reset value 0x70); E is reserved and treated as NOP; F HLT.

States:
- FETCH (00): if `cpu_en`, assert `load_ir`, `load_pc`, `imm=0`, `addr_sel=00`; go to DECODE. If not `cpu_en`, no strobes; stay in FETCH.
- DECODE (01), by opcode:
  - ALU ops: `rf_we=1`, `rf_src=00`, `flag_we=1`, `alu_op=opcode[2:0]`; go to FETCH.
  - MOV: `rf_we=1`, `rf_src=00`, `alu_op=100`, `flag_we=0`; go to FETCH.
  - LDR: `addr_sel=01`, `rf_we=1`, `rf_src=10`; go to FETCH.
  - STR: `addr_sel=01`, `mem_wr=1`; go to FETCH.
  - NOP/reserved: no strobes; go to FETCH.
  - HLT: no strobes; go to HALT.
  - 2-byte ops: `load_dr=1`, `load_pc=1`, `imm=0`; go to EXEC.
- EXEC (10), by opcode:
  - LDI: `rf_we=1`, `rf_src=01`.
  - LD: `addr_sel=10`, `rf_we=1`, `rf_src=10`.
  - ST: `addr_sel=10`, `mem_wr=1`.
  - Jump taken (JMP always; JZ when `alu_z`; JC when `alu_c`): `load_ir=1`, `load_pc=1`, `imm=1`, so IR <= mem[DR] and PC <= DR+1; go to DECODE, skipping FETCH.
  - Jump not taken, or any other opcode: no strobes; go to FETCH.
- HALT (11): no strobes; `seq_halt=1`; only reset exits.

Strobe rules:
- All outputs are combinational from state and `fetch_ir`.
- Every strobe not listed for a state is 0.
- `rd_idx`/`rs_idx` always reflect `fetch_ir`.

## Timing
- Reset: while `rst_n=0` at a posedge, state becomes FETCH. While `rst_n` is low, all strobes are forced to 0, `seq_halt=0` and `seq_state=00`.
- Cycle counts: ALU/MOV/LDR/STR/NOP take 2 cycles; 2-byte ops take 3; a taken jump takes 3 and its target instruction decodes in the very next cycle.
- Flags written in an ALU DECODE cycle are valid for a conditional jump's EXEC at least 2 cycles later. No bypass is needed.
- PC wrap: a jump to 0xFF yields PC = 0x00, and a fetch at 0xFF wraps PC to 0x00. No special handling.
- `cpu_en` low outside FETCH is ignored; the current instruction completes. `cpu_en` is ignored in HALT.
- Reset asserted mid-instruction (DECODE/EXEC) aborts it; no strobe is driven in the reset cycle.

## Structure
- Opcode localparams (OP_ADD…OP_HLT), state codes and the `rf_src`/`addr_sel`/`alu_op` encodings go in `scpu_parameter.h`, shared with the datapath.
- One natural sub-module: `scpu_op_decode`, a pure combinational classifier. Opcode in; is_alu, is_two_byte, is_jump, jump_taken (given `alu_z`/`alu_c`), is_halt out.
- The FSM and strobe generation stay in `scpu_sequencer`.

## Test plan
- Reset: hold `rst_n=0` 2 cycles with `fetch_ir=0x70` -> all strobes 0, `seq_state=00`. First cycle after release with `cpu_en=1` -> `load_ir=load_pc=1`, `imm=0`, `addr_sel=00`.
- ADD r1,r2 (0x06) -> DECODE: `rf_we=1`, `rf_src=00`, `alu_op=000`, `rd_idx=1`, `rs_idx=2`, `flag_we=1`; back in FETCH next cycle.
- LDI r3 (0x5C), then ST r0 (0x80) -> each DECODE: `load_dr=load_pc=1`. LDI EXEC: `rf_we=1`, `rf_src=01`. ST EXEC: `addr_sel=10`, `mem_wr=1`, `rf_we=0`.
- JZ (0xA0), `alu_z=1` -> EXEC: `load_ir=load_pc=imm=1`, next state DECODE. Repeat with `alu_z=0` -> EXEC has no strobes, next state FETCH.
- `cpu_en=0` for 3 cycles in FETCH -> no strobes, state stays 00. Then HLT (0xF0) -> HALT, `seq_halt=1` held for 10 cycles regardless of `cpu_en`. Reset -> FETCH.
- LDR r2,[r1] (0xC9) -> DECODE: `addr_sel=01`, `rf_src=10`, `rf_we=1`. STR (0xD9) -> `addr_sel=01`, `mem_wr=1`.
